// File: rtl/input_periph.sv
// rtl/input_periph.sv - switch/button input peripheral: sync, optional debounce (INPUT_DEBOUNCE_EN), press events, read port
module input_periph #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [17:0] i_sw,
    input  logic [3:0]  i_btn,
    input  logic [31:0] i_addr,
    input  logic        i_rd,
    output logic [31:0] o_rdata,
    output logic        o_rvalid
);

    localparam logic [31:0] ADDR_SW  = 32'h0000_7800;
    localparam logic [31:0] ADDR_BTN = 32'h0000_7810;
    localparam logic [31:0] ADDR_EVT = 32'h0000_7814;

    // bits [21:18] are the buttons, inverted to active-high; [17:0] are the switches
    logic [21:0] sync1;
    logic [21:0] sync2;
    logic [21:0] db;
    logic [21:0] db_next;
    logic [3:0]  btn_evt;
    logic [3:0]  evt_set;
    logic        rd_evt;
    logic [31:0] rdata_mux;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {~i_btn, i_sw};
            sync2 <= sync1;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic [21:0]   prev;
    logic [21:0]   db_q;
    logic [21:0]   agree;
    logic          tick;

    assign tick    = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign agree   = ~(sync2 ^ prev);
    // a bit only moves when two consecutive tick samples agree
    assign db_next = tick ? ((agree & sync2) | (~agree & db_q)) : db_q;
    assign db      = db_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            prev <= '0;
            db_q <= '0;
        end else begin
            cnt  <= tick ? '0 : cnt + CW'(1);
            db_q <= db_next;
            if (tick) begin
                prev <= sync2;
            end
        end
    end
`else
    logic unused_debounce_cfg;

    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign db                  = sync2;
    assign db_next             = sync1;
`endif

    assign evt_set = db_next[21:18] & ~db[21:18];
    assign rd_evt  = i_rd && (i_addr == ADDR_EVT);

    always_comb begin
        rdata_mux = 32'h0;
        case (i_addr)
            ADDR_SW:  rdata_mux = {14'b0, db[17:0]};
            ADDR_BTN: rdata_mux = {28'b0, db[21:18]};
            ADDR_EVT: rdata_mux = {28'b0, btn_evt};
            default:  rdata_mux = 32'h0;
        endcase
    end

    // a clearing read only drops bits it returned; a coincident new press still sets
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btn_evt  <= '0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= i_rd;
            if (i_rd) begin
                o_rdata <= rdata_mux;
            end
            btn_evt <= rd_evt ? evt_set : (btn_evt | evt_set);
        end
    end

endmodule

// File: tb/tb_input_periph.sv
// tb/tb_input_periph.sv - directed self-checking bench for input_periph
module tb_input_periph;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] sw;
    logic [3:0]  btn;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] rdata;
    logic        rvalid;

    int total = 0;
    int bad   = 0;

`ifdef INPUT_DEBOUNCE_EN
    localparam int LAT_LO = 6;
    localparam int LAT_HI = 11;
    localparam logic [31:0] GLITCH_EVT = 32'h0;
`else
    localparam int LAT_LO = 3;
    localparam int LAT_HI = 3;
    localparam logic [31:0] GLITCH_EVT = 32'h2;
`endif

    always #5 clk = ~clk;

    input_periph #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_sw    (sw),
        .i_btn   (btn),
        .i_addr  (addr),
        .i_rd    (rd),
        .o_rdata (rdata),
        .o_rvalid(rvalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the next negedge with the response sampled
    task automatic do_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        @(negedge clk);
        rd   = 1'b0;
        check("rvalid", {31'b0, rvalid}, 32'h1);
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic poll(input logic [31:0] a, input logic [31:0] exp, output int n, output logic [31:0] last);
        logic done;
        n    = 0;
        last = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            do_rd(a, last);
            n++;
            if (last === exp) done = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] first;
        int          n;
        int          got;

        rst_n = 1'b0;
        sw    = '0;
        btn   = 4'hF;
        addr  = '0;
        rd    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        rd_chk("sw_zero", 32'h7800, 32'h0);

        // switch debounce latency
        sw = 18'h2A5A5;
        poll(32'h7800, 32'h0002_A5A5, n, d);
        check("sw_value", d, 32'h0002_A5A5);
        check("sw_latency_in_window", {31'b0, (n >= LAT_LO && n <= LAT_HI)}, 32'h1);

        @(negedge clk);
        check("idle_rvalid", {31'b0, rvalid}, 32'h0);
        check("rdata_hold", rdata, 32'h0002_A5A5);

        // unmapped addresses, back-to-back
        rd_chk("addr_7804", 32'h7804, 32'h0);
        rd_chk("addr_7818", 32'h7818, 32'h0);
        rd_chk("addr_2000", 32'h2000, 32'h0);
        @(negedge clk);
        check("b2b_rvalid_end", {31'b0, rvalid}, 32'h0);

        // short glitch on button 1
        btn[1] = 1'b0;
        repeat (3) @(negedge clk);
        btn[1] = 1'b1;
        repeat (15) @(negedge clk);
        rd_chk("glitch_btn", 32'h7810, 32'h0);
        rd_chk("glitch_evt", 32'h7814, GLITCH_EVT);
        rd_chk("glitch_evt_clr", 32'h7814, 32'h0);

        // button 2 held 20 clocks
        btn[2] = 1'b0;
        repeat (15) @(negedge clk);
        rd_chk("held_btn", 32'h7810, 32'h4);
        repeat (4) @(negedge clk);
        btn[2] = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk("press_evt", 32'h7814, 32'h4);
        rd_chk("press_evt_clr", 32'h7814, 32'h0);
        rd_chk("release_btn", 32'h7810, 32'h0);
        rd_chk("sw_no_side_effect", 32'h7800, 32'h0002_A5A5);

        // button 0 press lands under continuous clearing reads
        btn[0] = 1'b0;
        got    = -1;
        first  = 0;
        for (int k = 0; k < 30 && got < 0; k++) begin
            do_rd(32'h7814, d);
            if (d != 0) begin
                got   = k;
                first = d;
            end
        end
        do_rd(32'h7814, d);
        check("coincide_pre_read_zero", {31'b0, (got >= 1)}, 32'h1);
        check("coincide_set_wins", first, 32'h1);
        check("coincide_then_clear", d, 32'h0);
        btn[0] = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk("release_no_evt", 32'h7814, 32'h0);

        // reset mid-debounce, button 3 held through reset
        btn[3] = 1'b0;
        sw     = 18'h3FFFF;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        addr  = 32'h7800;
        rd    = 1'b1;
        @(negedge clk);
        check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        rd    = 1'b0;
        @(negedge clk);
        check("dropped_read", {31'b0, rvalid}, 32'h0);
        poll(32'h7800, 32'h0003_FFFF, n, d);
        check("post_rst_sw", d, 32'h0003_FFFF);
        check("post_rst_latency", {31'b0, (n + 1 >= LAT_LO && n + 1 <= LAT_HI)}, 32'h1);
        repeat (10) @(negedge clk);
        rd_chk("held_thru_rst_evt", 32'h7814, 32'h8);
        rd_chk("held_thru_rst_btn", 32'h7810, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
